// File: rtl/boot_ctrl_pkg.sv
// rtl/boot_ctrl_pkg.sv - shared types and widths for the boot/run sequencer
package boot_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int HOLD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/boot_ctrl_if.sv
// rtl/boot_ctrl_if.sv - program word stream in, IMEM write port out
interface boot_ctrl_if #(
    parameter int ADDR_W = 8
);
    import boot_ctrl_pkg::*;

    logic [WORD_W-1:0] dataIN;
    logic              data_valid;
    logic              data_last;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output dataIN, data_valid, data_last,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  dataIN, data_valid, data_last,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/run_timer.sv
// rtl/run_timer.sv - enabled-cycle counter with optional run-limit compare
module run_timer
    import boot_ctrl_pkg::*;
#(
    parameter int unsigned RUN_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [WORD_W-1:0] cycle_count,
    output logic              limit_hit
);

    localparam logic [WORD_W-1:0] LIMIT_LAST =
        (RUN_LIMIT == 0) ? '0 : WORD_W'(RUN_LIMIT - 1);

    // Fires on the cycle whose increment makes the count equal RUN_LIMIT.
    assign limit_hit = (RUN_LIMIT != 0) && inc && (cycle_count == LIMIT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycle_count <= '0;
        end else if (inc) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - loads program words into IMEM, then releases and supervises the core
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter int          RESET_HOLD = 2,
    parameter int unsigned RUN_LIMIT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_start,
    input  logic              halt,
    boot_ctrl_if.slave        bus,
    output logic              core_rst,
    output logic              core_en,
    output logic [ADDR_W:0]   word_count,
    output logic [WORD_W-1:0] cycle_count,
    output logic              done,
    output logic              timeout,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(IMEM_DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              start;
    logic              limit_hit;

    assign bus.load_ready = (state == ST_LOAD) && en;
    assign accept         = bus.load_ready && bus.data_valid;
    assign start          = en && load_start && ((state == ST_IDLE) || (state == ST_DONE));

    // DONE leaves the core out of reset so its state can be inspected.
    assign core_rst = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_HOLD);
    assign core_en  = (state == ST_RUN) && en;
    assign done     = (state == ST_DONE);

    run_timer #(
        .RUN_LIMIT (RUN_LIMIT)
    ) u_run_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (start),
        .inc         (core_en),
        .cycle_count (cycle_count),
        .limit_hit   (limit_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            hold_cnt       <= '0;
            word_count     <= '0;
            timeout        <= 1'b0;
            err_overflow   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
        end else begin
            // The write strobe is registered off the accept, so it completes even if en drops.
            bus.imem_we <= accept;
            if (accept) begin
                bus.imem_waddr <= word_count[ADDR_W-1:0];
                bus.imem_wdata <= bus.dataIN;
                word_count     <= word_count + 1'b1;
            end

            if (en) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (load_start) begin
                            state        <= ST_LOAD;
                            word_count   <= '0;
                            timeout      <= 1'b0;
                            err_overflow <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            if (bus.data_last) begin
                                state    <= ST_HOLD;
                                hold_cnt <= '0;
                            end else if (word_count == LAST_WORD) begin
                                state        <= ST_HOLD;
                                hold_cnt     <= '0;
                                err_overflow <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= ST_RUN;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (halt) begin
                            state <= ST_DONE;
                        end else if (limit_hit) begin
                            state   <= ST_DONE;
                            timeout <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - directed self-checking bench for boot_ctrl
module tb_boot_ctrl;
    import boot_ctrl_pkg::*;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load_start = 1'b0;
    logic        halt = 1'b0;
    logic        core_rst, core_en, done, timeout, err_overflow;
    logic [AW:0] word_count;
    logic [31:0] cycle_count;
    logic [31:0] prog [4];
    int          checks = 0;
    int          failures = 0;

    boot_ctrl_if #(.ADDR_W(AW)) bus ();

    boot_ctrl #(
        .IMEM_DEPTH (16),
        .ADDR_W     (AW),
        .RESET_HOLD (2),
        .RUN_LIMIT  (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load_start   (load_start),
        .halt         (halt),
        .bus          (bus),
        .core_rst     (core_rst),
        .core_en      (core_en),
        .word_count   (word_count),
        .cycle_count  (cycle_count),
        .done         (done),
        .timeout      (timeout),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a load from IDLE/DONE, feed one final word, and walk through HOLD into RUN.
    task automatic load_one(input logic [31:0] word);
        load_start = 1'b1;
        step(1);
        load_start = 1'b0;
        chk("reload_ready", bus.load_ready, 1);
        chk("reload_core_rst", core_rst, 1);
        chk("reload_wcount", word_count, 0);
        chk("reload_cycles", cycle_count, 0);
        chk("reload_done", done, 0);
        bus.dataIN     = word;
        bus.data_valid = 1'b1;
        bus.data_last  = 1'b1;
        step(1);
        chk("reload_we", bus.imem_we, 1);
        chk("reload_waddr", bus.imem_waddr, 0);
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        step(2);
        chk("reload_run_rst", core_rst, 0);
        chk("reload_run_en", core_en, 1);
    endtask

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0010_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0010_0073;
        bus.dataIN     = '0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;

        step(2);
        chk("rst_load_ready", bus.load_ready, 0);
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_waddr", bus.imem_waddr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_wcount", word_count, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_status", {done, timeout, err_overflow}, 0);
        rst = 1'b0;
        step(1);
        chk("idle_ready", bus.load_ready, 0);

        // Normal four-word load
        load_start = 1'b1;
        step(1);
        load_start = 1'b0;
        chk("load_ready", bus.load_ready, 1);
        chk("load_core_rst", core_rst, 1);
        for (int i = 0; i < 4; i++) begin
            bus.dataIN     = prog[i];
            bus.data_valid = 1'b1;
            bus.data_last  = (i == 3);
            step(1);
            chk("norm_we", bus.imem_we, 1);
            chk("norm_waddr", bus.imem_waddr, i);
            chk("norm_wdata", bus.imem_wdata, prog[i]);
        end
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        chk("norm_wcount", word_count, 4);
        chk("hold1_core_rst", core_rst, 1);
        chk("hold1_ready", bus.load_ready, 0);
        step(1);
        chk("hold2_core_rst", core_rst, 1);
        chk("hold2_we", bus.imem_we, 0);
        step(1);
        chk("run_core_rst", core_rst, 0);
        chk("run_core_en", core_en, 1);
        chk("run_cycles0", cycle_count, 0);

        // Halt on the 7th RUN cycle
        step(6);
        chk("halt_pre_cycles", cycle_count, 6);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        chk("halt_cycles", cycle_count, 7);
        chk("halt_done", done, 1);
        chk("halt_timeout", timeout, 0);
        chk("halt_core_en", core_en, 0);
        chk("halt_core_rst", core_rst, 0);
        step(2);
        chk("done_cycles_hold", cycle_count, 7);
        chk("done_stays", done, 1);

        // Reload from DONE, freeze mid-RUN, then run into the limit
        load_one(32'h1111_0001);
        step(3);
        chk("frz_pre_cycles", cycle_count, 3);
        en = 1'b0;
        #1;
        chk("frz_core_en", core_en, 0);
        step(5);
        chk("frz_cycles", cycle_count, 3);
        chk("frz_core_rst", core_rst, 0);
        chk("frz_done", done, 0);
        en = 1'b1;
        #1;
        chk("unfrz_core_en", core_en, 1);
        step(1);
        chk("unfrz_cycles", cycle_count, 4);
        step(15);
        chk("to_pre_cycles", cycle_count, 19);
        chk("to_pre_done", done, 0);
        step(1);
        chk("to_cycles", cycle_count, 20);
        chk("to_done", done, 1);
        chk("to_timeout", timeout, 1);
        chk("to_core_en", core_en, 0);

        // Halt coinciding with the limit: halt wins
        load_one(32'h2222_0002);
        chk("sim_timeout_clr", timeout, 0);
        step(19);
        chk("sim_pre_cycles", cycle_count, 19);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        chk("sim_cycles", cycle_count, 20);
        chk("sim_done", done, 1);
        chk("sim_timeout", timeout, 0);

        // Overflow with an en freeze mid-LOAD
        load_start = 1'b1;
        step(1);
        load_start = 1'b0;
        chk("ovf_wcount0", word_count, 0);
        for (int i = 0; i < 16; i++) begin
            bus.dataIN     = 32'hA000_0000 + i;
            bus.data_valid = 1'b1;
            bus.data_last  = 1'b0;
            if (i == 5) begin
                en = 1'b0;
                #1;
                chk("lfrz_ready", bus.load_ready, 0);
                step(1);
                chk("lfrz_we", bus.imem_we, 0);
                chk("lfrz_wcount", word_count, 5);
                step(4);
                chk("lfrz_wcount_end", word_count, 5);
                chk("lfrz_core_rst", core_rst, 1);
                en = 1'b1;
            end
            step(1);
            chk("ovf_we", bus.imem_we, 1);
            chk("ovf_waddr", bus.imem_waddr, i);
            chk("ovf_wdata", bus.imem_wdata, 32'hA000_0000 + i);
        end
        chk("ovf_err", err_overflow, 1);
        chk("ovf_wcount", word_count, 16);
        bus.dataIN = 32'hA000_0010;
        #1;
        chk("ovf_17_ready", bus.load_ready, 0);
        step(1);
        chk("ovf_17_we", bus.imem_we, 0);
        chk("ovf_17_wcount", word_count, 16);
        bus.data_valid = 1'b0;
        step(1);
        chk("ovf_run_rst", core_rst, 0);
        chk("ovf_run_en", core_en, 1);
        chk("ovf_err_sticky", err_overflow, 1);

        // Reset mid-RUN
        step(2);
        chk("mid_run_cycles", cycle_count, 2);
        rst = 1'b1;
        step(1);
        chk("mrst_core_rst", core_rst, 1);
        chk("mrst_core_en", core_en, 0);
        chk("mrst_wcount", word_count, 0);
        chk("mrst_cycles", cycle_count, 0);
        chk("mrst_wdata", bus.imem_wdata, 0);
        chk("mrst_waddr", bus.imem_waddr, 0);
        chk("mrst_status", {done, timeout, err_overflow}, 0);
        rst = 1'b0;
        halt = 1'b1;
        step(2);
        halt = 1'b0;
        chk("idle_halt_ignored", done, 0);
        chk("idle_core_rst", core_rst, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
